// File: rtl/pic8259_pkg.sv
// Shared constants for the 8259A-compatible PIC: bus width and the data bits
// that steer A0=0 writes between ICW1, OCW2 and OCW3.
package pic8259_pkg;
  localparam int BUS_W        = 8;
  localparam int ICW1_SEL_BIT = 4;
  localparam int OCW3_SEL_BIT = 3;
endpackage

// File: rtl/pic_edge_detect.sv
// One-clock pulse on the rising edge of level_i. The previous-level register resets
// high, so a level that is already high when reset releases produces no pulse.
module pic_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic level_i,
  output logic rise_o
);
  logic prev_q;

  always_ff @(posedge clock) begin
    if (!reset_n) prev_q <= 1'b1;
    else          prev_q <= level_i;
  end

  assign rise_o = reset_n & ~prev_q & level_i;
endmodule

// File: rtl/data_bus_control_8259.sv
// Host-bus front end of the PIC: latches CPU write data and address, and decodes each
// completed write (effective strobe release) into one-cycle ICW/OCW strobes. Read is a pure level.
module data_bus_control_8259
  import pic8259_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             chip_select_n,
  input  logic             read_enable_n,
  input  logic             write_enable_n,
  input  logic             address,
  input  logic [BUS_W-1:0] data_bus_in,
  output logic [BUS_W-1:0] internal_data_bus,
  output logic             write_initial_command_word_1,
  output logic             write_initial_command_word_2_4,
  output logic             write_operation_control_word_1,
  output logic             write_operation_control_word_2,
  output logic             write_operation_control_word_3,
  output logic             read,
  output logic             write_out
);
  logic             wr_eff;
  logic             write_flag;
  logic [BUS_W-1:0] data_q, data_d;
  logic             addr_q, addr_d;

  assign wr_eff = write_enable_n | chip_select_n;

  pic_edge_detect u_wr_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .level_i (wr_eff),
    .rise_o  (write_flag)
  );

  // Keep tracking the bus while the write is active; the last value before release wins.
  always_comb begin
    data_d = data_q;
    addr_d = addr_q;
    if (!wr_eff) begin
      data_d = data_bus_in;
      addr_d = address;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_q <= '0;
      addr_q <= 1'b0;
    end else begin
      data_q <= data_d;
      addr_q <= addr_d;
    end
  end

  assign internal_data_bus = data_q;

  // ICW2-4 and OCW1 share a decode; the control logic tells them apart by init state.
  assign write_initial_command_word_1   = write_flag & ~addr_q &  data_q[ICW1_SEL_BIT];
  assign write_initial_command_word_2_4 = write_flag &  addr_q;
  assign write_operation_control_word_1 = write_flag &  addr_q;
  assign write_operation_control_word_2 = write_flag & ~addr_q & ~data_q[ICW1_SEL_BIT] & ~data_q[OCW3_SEL_BIT];
  assign write_operation_control_word_3 = write_flag & ~addr_q & ~data_q[ICW1_SEL_BIT] &  data_q[OCW3_SEL_BIT];
  assign write_out                      = write_flag;

  assign read = ~read_enable_n & ~chip_select_n;
endmodule

// File: tb/tb_data_bus_control_8259.sv
// Directed and random stimulus for the PIC bus front end, checked each cycle against a
// transaction-level model: writes as begin/end events, strobes derived from the write's A0 and data.
module tb_data_bus_control_8259;
  logic       clk = 1'b0;
  logic       rst_n, cs_n, rd_n, wr_n, a0;
  logic [7:0] din;
  logic [7:0] dbus;
  logic       icw1, icw24, ocw1, ocw2, ocw3, rd_lvl, wout;

  int checks = 0;
  int errors = 0;

  // Model: a write is "open" once the CPU has held CS_n/WR_n low across a clock edge
  // outside reset; it completes when the strobe is seen released.
  bit         m_open;
  logic [7:0] m_data;
  bit         m_a0;
  logic [5:0] obs_vec;

  always #5 clk = ~clk;

  data_bus_control_8259 dut (
    .clock                          (clk),
    .reset_n                        (rst_n),
    .chip_select_n                  (cs_n),
    .read_enable_n                  (rd_n),
    .write_enable_n                 (wr_n),
    .address                        (a0),
    .data_bus_in                    (din),
    .internal_data_bus              (dbus),
    .write_initial_command_word_1   (icw1),
    .write_initial_command_word_2_4 (icw24),
    .write_operation_control_word_1 (ocw1),
    .write_operation_control_word_2 (ocw2),
    .write_operation_control_word_3 (ocw3),
    .read                           (rd_lvl),
    .write_out                      (wout)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    bit done;
    bit e_icw1, e_icw24, e_ocw2, e_ocw3;
    done    = rst_n && m_open && !(!wr_n && !cs_n);
    e_icw24 = done && m_a0;
    e_icw1  = done && !m_a0 && (m_data >= 8'h10) && ((m_data / 16) % 2 == 1);
    e_ocw3  = done && !m_a0 && !e_icw1 && ((m_data / 8) % 2 == 1);
    e_ocw2  = done && !m_a0 && !e_icw1 && !e_ocw3;
    chk("dbus",  dbus,   m_data);
    chk("icw1",  {7'd0, icw1},  {7'd0, e_icw1});
    chk("icw24", {7'd0, icw24}, {7'd0, e_icw24});
    chk("ocw1",  {7'd0, ocw1},  {7'd0, e_icw24});
    chk("ocw2",  {7'd0, ocw2},  {7'd0, e_ocw2});
    chk("ocw3",  {7'd0, ocw3},  {7'd0, e_ocw3});
    chk("wout",  {7'd0, wout},  {7'd0, done});
    chk("read",  {7'd0, rd_lvl}, {7'd0, (!rd_n && !cs_n)});
    obs_vec = {icw1, icw24, ocw1, ocw2, ocw3, wout};
  endtask

  task automatic step(input logic r, input logic c, input logic rd, input logic wr,
                      input logic a, input logic [7:0] d);
    rst_n = r; cs_n = c; rd_n = rd; wr_n = wr; a0 = a; din = d;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    if (!r) begin
      m_open = 1'b0; m_data = 8'h00; m_a0 = 1'b0;
    end else begin
      m_open = !wr && !c;
      if (!wr && !c) begin
        m_data = d; m_a0 = a;
      end
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; a0 = 1'b0; din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    m_open = 1'b0; m_data = 8'h00; m_a0 = 1'b0;

    repeat (10) step(0, 1, 1, 1, 0, 8'hA5);

    step(1, 0, 1, 0, 0, 8'h10);
    step(1, 1, 1, 1, 0, 8'hFF);
    chk("icw1_write_vec", {2'b00, obs_vec}, 8'b0010_0001);
    chk("icw1_write_dbus", dbus, 8'h10);

    step(1, 0, 1, 0, 1, 8'h00);
    step(1, 1, 1, 1, 0, 8'hFF);
    chk("icw24_write_vec", {2'b00, obs_vec}, 8'b0001_1001);

    step(1, 0, 1, 0, 0, 8'h00);
    step(1, 1, 1, 1, 0, 8'hFF);
    chk("ocw2_write_vec", {2'b00, obs_vec}, 8'b0000_0101);

    step(1, 0, 1, 0, 0, 8'h08);
    step(1, 1, 1, 1, 0, 8'hFF);
    chk("ocw3_write_vec", {2'b00, obs_vec}, 8'b0000_0011);

    // Long write with changing data: the last value before release decodes.
    step(1, 0, 1, 0, 0, 8'h08);
    step(1, 0, 1, 0, 0, 8'h00);
    step(1, 0, 1, 0, 0, 8'h18);
    step(1, 0, 1, 1, 0, 8'h00);
    chk("long_write_vec", {2'b00, obs_vec}, 8'b0010_0001);
    step(1, 1, 1, 1, 0, 8'h00);
    chk("long_write_single", {2'b00, obs_vec}, 8'h00);

    step(1, 0, 0, 1, 0, 8'h00);
    chk("read_level", {7'd0, rd_lvl}, 8'h01);
    step(1, 0, 1, 1, 0, 8'h00);
    chk("read_release", {7'd0, rd_lvl}, 8'h00);

    step(1, 1, 1, 0, 0, 8'h77);
    step(1, 1, 1, 1, 0, 8'h77);
    chk("cs_high_vec", {2'b00, obs_vec}, 8'h00);
    chk("cs_high_dbus", dbus, 8'h18);

    step(1, 0, 1, 0, 0, 8'h55);
    step(0, 0, 1, 0, 0, 8'h55);
    step(0, 0, 1, 1, 0, 8'h55);
    step(1, 1, 1, 1, 0, 8'h55);
    chk("reset_mid_vec", {2'b00, obs_vec}, 8'h00);
    chk("reset_mid_dbus", dbus, 8'h00);

    for (int i = 0; i < 600; i++) begin
      step(($urandom % 40) != 0, ($urandom % 4) == 0, $urandom % 2,
           ($urandom % 3) == 0, $urandom % 2, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
